// File: rtl/power_pkg.sv
// rtl/power_pkg.sv - shared state types and default 100 MHz timing for power_ctrl
//
// Purpose : FSM state enum, gesture-direction enum and default cycle counts
//           used by power_ctrl and its test environment.
// Ports   : none (package).
package power_pkg;

  typedef enum logic [2:0] {
    OFF,
    ON_HELD,
    ON,
    ON_LONG,
    OFF_HELD
  } pwr_state_t;

  typedef enum logic [1:0] {
    NONE,
    L,
    R
  } gest_dir_t;

  // 20 ms debounce, 3 s long press, 5 s gesture window at 100 MHz
  localparam int DEF_DEBOUNCE_CYC = 2_000_000;
  localparam int DEF_LONG_CYC     = 300_000_000;
  localparam int DEF_WINDOW_CYC   = 500_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debouncer and rise-edge event
//
// Purpose : brings a raw asynchronous button into the clk domain through a
//           2-flop synchroniser, filters bounce, and flags rising edges of the
//           filtered level.
// Ports   : clk    in  system clock
//           rst_n  in  synchronous active-low reset
//           btn    in  raw button, active-high, asynchronous
//           level  out debounced button level
//           rise   out one-cycle strobe on a debounced 0->1 change
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      // Count cycles where the synchronised value disagrees with the filtered
      // level; any agreement (a bounce back) restarts the count from zero.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // level_q is the previous filtered level, so this is high for one cycle only
  assign rise = level & ~level_q;

endmodule

// File: rtl/power_ctrl.sv
// rtl/power_ctrl.sv - power-state controller for the front-panel power button
//
// Purpose : short press turns the unit on, a sustained long press turns it
//           off; optional two-button gesture (left/right) when the macro
//           POWER_GESTURE_EN is defined.
// Ports   : clk        in  system clock
//           rst_n      in  synchronous active-low reset
//           btn_power  in  raw power button, active-high, asynchronous
//           btn_left   in  raw left button (gesture build only)
//           btn_right  in  raw right button (gesture build only)
//           power_on   out registered power level to the output stage
//           on_pulse   out one-cycle strobe when power_on rises
//           off_pulse  out one-cycle strobe when power_on falls
module power_ctrl
  import power_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int WINDOW_CYC   = DEF_WINDOW_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_power,
  input  logic btn_left,
  input  logic btn_right,
  output logic power_on,
  output logic on_pulse,
  output logic off_pulse
);

  localparam int HW = $clog2(LONG_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);

  logic pwr_lvl, pwr_rise;
  logic left_lvl, left_rise;
  logic right_lvl, right_rise;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_power (
    .clk(clk), .rst_n(rst_n), .btn(btn_power), .level(pwr_lvl), .rise(pwr_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn(btn_left), .level(left_lvl), .rise(left_rise)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn(btn_right), .level(right_lvl), .rise(right_rise)
  );

  pwr_state_t    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          power_nxt;
  logic          gest_hit_on;
  logic          gest_hit_off;

`ifdef POWER_GESTURE_EN
  localparam int WW = $clog2(WINDOW_CYC + 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(WINDOW_CYC);

  gest_dir_t     dir, dir_nxt;
  logic [WW-1:0] win, win_nxt;
  logic          unused_lvls;

  assign unused_lvls = left_lvl ^ right_lvl;

  // A completion edge is accepted while the window has not yet run out,
  // including the cycle in which it steps from 1 to 0.
  assign gest_hit_on  = (state == OFF) && (dir == L) && right_rise && (win != '0);
  assign gest_hit_off = (state == ON)  && (dir == R) && left_rise  && (win != '0);

  always_comb begin
    dir_nxt = dir;
    win_nxt = win;
    if (win != '0) begin
      win_nxt = win - WW'(1);
    end
    if ((dir != NONE) && (win == '0)) begin
      dir_nxt = NONE;
    end
    if ((state == OFF) && left_rise) begin
      dir_nxt = L;
      win_nxt = WIN_MAX;
    end else if ((state == ON) && right_rise) begin
      dir_nxt = R;
      win_nxt = WIN_MAX;
    end
    // Any power change, or leaving the idle OFF/ON states, drops the gesture.
    if ((power_nxt != power_on) || ((state_nxt != OFF) && (state_nxt != ON))) begin
      dir_nxt = NONE;
      win_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dir <= NONE;
      win <= '0;
    end else begin
      dir <= dir_nxt;
      win <= win_nxt;
    end
  end
`else
  logic unused_inputs;

  assign unused_inputs = left_lvl ^ left_rise ^ right_lvl ^ right_rise ^ (WINDOW_CYC > 0);
  assign gest_hit_on   = 1'b0;
  assign gest_hit_off  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    power_nxt = power_on;
    case (state)
      OFF: begin
        if (pwr_rise) begin
          state_nxt = ON_HELD;
          power_nxt = 1'b1;
        end
      end
      ON_HELD: begin
        if (!pwr_lvl) begin
          state_nxt = ON;
        end
      end
      ON: begin
        if (pwr_lvl) begin
          state_nxt = ON_LONG;
          hold_nxt  = '0;
        end
      end
      ON_LONG: begin
        if (!pwr_lvl) begin
          state_nxt = ON;
        end else begin
          hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);
          if (hold_nxt == HOLD_MAX) begin
            state_nxt = OFF_HELD;
            power_nxt = 1'b0;
          end
        end
      end
      OFF_HELD: begin
        if (!pwr_lvl) begin
          state_nxt = OFF;
        end
      end
      default: begin
        state_nxt = OFF;
        power_nxt = 1'b0;
      end
    endcase
    // Gestures only act when the power button caused no transition this cycle.
    if (state_nxt == state) begin
      if (gest_hit_on) begin
        state_nxt = ON;
        power_nxt = 1'b1;
      end else if (gest_hit_off) begin
        state_nxt = OFF;
        power_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      hold_cnt  <= '0;
      power_on  <= 1'b0;
      on_pulse  <= 1'b0;
      off_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      power_on  <= power_nxt;
      on_pulse  <= power_nxt & ~power_on;
      off_pulse <= ~power_nxt & power_on;
    end
  end

endmodule

// File: tb/tb_power_ctrl.sv
// tb/tb_power_ctrl.sv - self-checking bench for power_ctrl
module tb_power_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_power;
  logic btn_left;
  logic btn_right;
  logic power_on;
  logic on_pulse;
  logic off_pulse;

  always #5 clk = ~clk;

  power_ctrl #(
    .DEBOUNCE_CYC(4),
    .LONG_CYC(20),
    .WINDOW_CYC(50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_power(btn_power),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .power_on(power_on),
    .on_pulse(on_pulse),
    .off_pulse(off_pulse)
  );

  localparam int NOP  = 0;
  localparam int ONP  = 1;
  localparam int OFFP = 2;

  // Inputs held for len cycles; kind/at give the one pulse expected in it.
  typedef struct {
    logic rst_n;
    logic pwr;
    logic lft;
    logic rgt;
    int   len;
    int   kind;
    int   at;
  } seg_t;

  seg_t       tbl[$];
  logic [2:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         seg_no = 0;
  logic       exp_po = 1'b0;

  task automatic add(input logic r, input logic p, input logic l, input logic rr,
                     input int len, input int kind, input int at);
    seg_t s;
    s.rst_n = r; s.pwr = p; s.lft = l; s.rgt = rr;
    s.len = len; s.kind = kind; s.at = at;
    tbl.push_back(s);
  endtask

  // Cycle k: inputs driven before edge k, outputs sampled on the next negedge.
  task automatic run_seg(input seg_t s);
    logic [2:0] e;
    logic [2:0] got;
    for (int k = 0; k < s.len; k++) begin
      rst_n     = s.rst_n;
      btn_power = s.pwr;
      btn_left  = s.lft;
      btn_right = s.rgt;
      e = 3'b000;
      if (!s.rst_n) begin
        exp_po = 1'b0;
      end else if ((k == s.at) && (s.kind == ONP)) begin
        exp_po = 1'b1;
        e[1]   = 1'b1;
      end else if ((k == s.at) && (s.kind == OFFP)) begin
        exp_po = 1'b0;
        e[0]   = 1'b1;
      end
      e[2] = exp_po;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = {power_on, on_pulse, off_pulse};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL seg%0d cycle %0d {power_on,on_pulse,off_pulse}: got %b expected %b",
                 seg_no, k, got, e);
      end
    end
    seg_no++;
  endtask

  task automatic seg(input logic r, input logic p, input logic l, input logic rr,
                     input int len, input int kind, input int at);
    seg_t s;
    s.rst_n = r; s.pwr = p; s.lft = l; s.rgt = rr;
    s.len = len; s.kind = kind; s.at = at;
    run_seg(s);
  endtask

  initial begin
    rst_n = 1'b0; btn_power = 1'b1; btn_left = 1'b1; btn_right = 1'b1;

    add(0, 1, 1, 1,  3, NOP,  0);  // reset with all buttons high
    add(1, 0, 0, 0, 10, NOP,  0);
    add(1, 1, 0, 0, 10, ONP,  7);  // short press: on at cycle 7
    add(1, 0, 0, 0, 12, NOP,  0);  // stays on after release
    add(1, 1, 0, 0,  3, NOP,  0);  // 3-cycle glitch
    add(1, 0, 0, 0, 12, NOP,  0);
    add(1, 1, 0, 0, 30, OFFP, 27); // long press: debounced(6)+21
    add(1, 0, 0, 0, 12, NOP,  0);  // OFF_HELD -> OFF
    add(1, 1, 0, 0, 40, ONP,  7);  // power-on press held 40 cycles stays on
    add(1, 0, 0, 0, 12, NOP,  0);
    add(1, 1, 0, 0, 15, NOP,  0);  // 15-cycle hold stays on
    add(1, 0, 0, 0, 12, NOP,  0);
    add(1, 1, 0, 0, 18, NOP,  0);  // into ON_LONG, hold count ~10
    add(0, 1, 0, 0,  3, NOP,  0);  // reset mid-hold: off, no off_pulse
    add(1, 0, 0, 0, 10, NOP,  0);
    add(1, 1, 0, 0, 10, ONP,  7);  // re-press powers on
    add(1, 0, 0, 0, 12, NOP,  0);
    add(1, 1, 0, 0, 30, OFFP, 27);
    add(1, 0, 0, 0, 12, NOP,  0);  // back to OFF

    for (int i = 0; i < tbl.size(); i++) begin
      run_seg(tbl[i]);
    end

    // Bounce: the one-cycle drop restarts the debounce count.
    seg(1, 1, 0, 0,  3, NOP,  0);
    seg(1, 0, 0, 0,  1, NOP,  0);
    seg(1, 1, 0, 0, 10, ONP,  7);
    seg(1, 0, 0, 0, 12, NOP,  0);
    seg(1, 1, 0, 0, 30, OFFP, 27);
    seg(1, 0, 0, 0, 12, NOP,  0);

`ifdef POWER_GESTURE_EN
    // OFF: left then right 30 cycles apart -> on
    seg(1, 0, 1, 0, 10, NOP,  0);
    seg(1, 0, 0, 0, 20, NOP,  0);
    seg(1, 0, 0, 1, 10, ONP,  7);
    seg(1, 0, 0, 0, 12, NOP,  0);
    // ON: right then left -> off
    seg(1, 0, 0, 1, 10, NOP,  0);
    seg(1, 0, 0, 0, 20, NOP,  0);
    seg(1, 0, 1, 0, 10, OFFP, 7);
    seg(1, 0, 0, 0, 12, NOP,  0);
    // right edge 60 cycles after left -> window expired, stays off
    seg(1, 0, 1, 0, 10, NOP,  0);
    seg(1, 0, 0, 0, 50, NOP,  0);
    seg(1, 0, 0, 1, 10, NOP,  0);
    seg(1, 0, 0, 0, 12, NOP,  0);
    // pwr_rise together with gesture completion: button wins (ON_HELD),
    // so holding power for 40 cycles never powers off
    seg(1, 0, 1, 0, 10, NOP,  0);
    seg(1, 0, 0, 0, 10, NOP,  0);
    seg(1, 1, 0, 1, 40, ONP,  7);
    seg(1, 0, 0, 0, 12, NOP,  0);
`else
    // Gesture not built: left then right leaves power off
    seg(1, 0, 1, 0, 10, NOP,  0);
    seg(1, 0, 0, 0, 20, NOP,  0);
    seg(1, 0, 0, 1, 10, NOP,  0);
    seg(1, 0, 0, 0, 12, NOP,  0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
